gpr_file_sb: RTL and testbench
==============================

# gpr_file_sb

- Parametrised general-purpose register file with an integrated scoreboard, for the NPC integer datapath between decode and writeback.
- Provides NRD combinational read ports with same-cycle write bypass, one write port and a hardwired-zero register 0.
- Keeps per-register busy bits so decode can detect RAW hazards on in-flight destinations.
- Clears its storage after reset with a one-register-per-cycle sweep, so it maps onto RAM-style arrays with no per-entry reset.

## Interface
Parameters:
- XLEN, 64, data width of each register
- NREG, 32, number of registers (power of two, ≥ 4); AW = $clog2(NREG)
- NRD, 2, number of read ports (1..4)

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces INIT state immediately
- ready  out  1  1 once the init sweep is done; 0 during INIT
- rsAddr  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
- rsData  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
- rsBusy  out  NRD  1 = port k's register has a pending write
- wbValid  in  1  writeback strobe
- wbAddr  in  AW  writeback destination
- wbData  in  XLEN  writeback data
- issueValid  in  1  instruction with a destination issued this cycle
- issueRd  in  AW  destination of the issued instruction
- flush  in  1  clear all busy bits (pipeline kill); storage untouched
- dbgAddr  in  AW  debug/difftest read address
- dbgData  out  XLEN  raw array content at dbgAddr, no bypass

## Operation
- State machine with two states:
  - INIT: entered on reset low. Sweep counter starts at 1, writes 0 to register[counter] and increments each cycle. Moves to RUN after writing NREG-1.
  - RUN: normal operation.
- Busy bits reset asynchronously to 0. ready is 0 in INIT and on reset.
- In INIT:
  - wbValid, issueValid and flush are ignored.
  - rsData = 0, rsBusy = 0, dbgData = 0.
- Read path in RUN, per port k:
  - rsAddr = 0 gives rsData = 0 and rsBusy = 0.
  - If wbValid and wbAddr == rsAddr, rsData = wbData (bypass); otherwise rsData = array content.
- Write in RUN: wbValid with wbAddr ≠ 0 writes wbData at the edge. wbAddr = 0 is dropped.
- Busy-bit update at each edge, for register r ≠ 0, in priority order:
  1. flush: all bits cleared, and any same-cycle issue is also discarded.
  2. issueValid with issueRd = r: set. Issue wins over a same-cycle writeback to r, because the newer producer is still in flight.
  3. wbValid with wbAddr = r: clear.
- rsBusy is combinational from the pre-edge busy bit. A same-cycle writeback to the read address masks it to 0, since the bypass already delivers the data.
- Issue with issueRd = 0 never sets a busy bit. The busy bit for register 0 is constant 0.
- Issuing to an already-busy register is legal; the bit stays set.
- All address and data widths are exact; there is no truncation or sign handling.

## Timing
- Read data and busy have 0-cycle latency (combinational from rsAddr, wb*, and state).
- Write is visible in the array after 1 edge, and through the bypass in the same cycle.
- Init sweep: after reset rises, edges 1..NREG-1 write registers 1..NREG-1. ready goes to 1 after edge NREG-1 (edge 31 for defaults).
- Reset asserted mid-sweep or mid-RUN: INIT is re-entered immediately, the counter restarts at 1, and all busy bits clear asynchronously. Array contents are not guaranteed until ready.
- There is no backpressure. The producer must gate issue, writeback and flush on ready.

## Structure
- A shared package holds:
  - the state enum (INIT, RUN);
  - defaults for XLEN, NREG and NRD;
  - the AW helper function.
- One sub-module, gpr_scoreboard. It holds the busy vector, implements the flush > issue > writeback priority, and exposes a per-address busy lookup with the writeback mask.
- The top level holds the array, the sweep FSM, the read muxes with bypass, and the debug port.

## Test plan
- Reset release, defaults: ready = 0 for edges 0..30 and 1 after edge 31; then reading every register gives 0 and rsBusy = 0.
- Write x5 = 0xDEAD_BEEF_0000_0001 while reading rsAddr0 = 5 in the same cycle → rsData0 = 0xDEAD_BEEF_0000_0001 in that cycle. dbgData(5) shows the old value that cycle and the new value the next cycle.
- Write x0 = 0xFFFF_FFFF_FFFF_FFFF, then read x0 → 0. Issue rd = 0, then read x0 → rsBusy = 0.
- Issue rd = 7, then read x7 → busy = 1. A same-cycle issue rd = 7 plus wbAddr = 7 leaves busy = 1. A lone wbAddr = 7 clears it, and rsBusy is already 0 during that writeback cycle.
- Issue rd = 3, 4, 9, then flush with a concurrent issue rd = 12 → all busy bits are 0 and x12 is not busy.
- Drop reset low at sweep edge 10 and during RUN with busy bits set → ready falls to 0 and busy clears immediately. The full sweep restarts and completes in 31 edges, and all registers read 0.

Source files
------------

// File: rtl/gpr_file_sb_pkg.sv
// Shared types and defaults for the integer register file with scoreboard.
package gpr_file_sb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;

  function automatic int addr_w(input int nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits with flush > issue > writeback priority and a
// per-port lookup that hides busy when the writeback is bypassed this cycle.
module gpr_scoreboard
  import gpr_file_sb_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = NRD_DEF,
  localparam int AW   = addr_w(NREG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Issue is applied after writeback so the newer producer keeps the bit set.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid)
      busy_nxt[wb_addr] = 1'b0;
    if (issue_valid)
      busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      busy <= '0;
    else if (run)
      busy <= flush ? '0 : busy_nxt;
  end

  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_busy[k] = run
                 && (rd_addr[k*AW +: AW] != '0)
                 && busy[rd_addr[k*AW +: AW]]
                 && !(wb_valid && (wb_addr == rd_addr[k*AW +: AW]));
    end
  end

endmodule

// File: rtl/gpr_file_sb.sv
// Register file with hardwired-zero x0, write bypass, scoreboard and a
// post-reset clearing sweep so the array needs no per-entry reset.
module gpr_file_sb
  import gpr_file_sb_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = NRD_DEF,
  localparam int AW   = addr_w(NREG)
) (
  input  logic                clock,
  input  logic                reset,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rsAddr,
  output logic [NRD*XLEN-1:0] rsData,
  output logic [NRD-1:0]      rsBusy,
  input  logic                wbValid,
  input  logic [AW-1:0]       wbAddr,
  input  logic [XLEN-1:0]     wbData,
  input  logic                issueValid,
  input  logic [AW-1:0]       issueRd,
  input  logic                flush,
  input  logic [AW-1:0]       dbgAddr,
  output logic [XLEN-1:0]     dbgData
);

  state_e          state;
  logic [AW-1:0]   sweep_idx;
  logic            run;
  logic [XLEN-1:0] mem [NREG];
  logic            we;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;

  assign run = (state == ST_RUN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_INIT;
      sweep_idx <= AW'(1);
      ready     <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          sweep_idx <= sweep_idx + AW'(1);
          if (sweep_idx == AW'(NREG - 1)) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_RUN;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // The sweep owns the single write port until RUN.
  always_comb begin
    we = 1'b0;
    wa = wbAddr;
    wd = wbData;
    if (!run) begin
      we = 1'b1;
      wa = sweep_idx;
      wd = '0;
    end else if (wbValid && (wbAddr != '0)) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (we)
      mem[wa] <= wd;
  end

  always_comb begin
    rsData = '0;
    for (int k = 0; k < NRD; k++) begin
      if (run && (rsAddr[k*AW +: AW] != '0)) begin
        if (wbValid && (wbAddr == rsAddr[k*AW +: AW]))
          rsData[k*XLEN +: XLEN] = wbData;
        else
          rsData[k*XLEN +: XLEN] = mem[rsAddr[k*AW +: AW]];
      end
    end
  end

  assign dbgData = run ? mem[dbgAddr] : '0;

  gpr_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD)
  ) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .flush       (flush),
    .issue_valid (issueValid),
    .issue_rd    (issueRd),
    .wb_valid    (wbValid),
    .wb_addr     (wbAddr),
    .rd_addr     (rsAddr),
    .rd_busy     (rsBusy)
  );

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed plus randomized bench for gpr_file_sb against a behavioural model.
module tb_gpr_file_sb;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                ready;
  logic [NRD*AW-1:0]   rsAddr;
  logic [NRD*XLEN-1:0] rsData;
  logic [NRD-1:0]      rsBusy;
  logic                wbValid = 1'b0;
  logic [AW-1:0]       wbAddr = '0;
  logic [XLEN-1:0]     wbData = '0;
  logic                issueValid = 1'b0;
  logic [AW-1:0]       issueRd = '0;
  logic                flush = 1'b0;
  logic [AW-1:0]       dbgAddr = '0;
  logic [XLEN-1:0]     dbgData;
  logic [AW-1:0]       ra0 = '0;
  logic [AW-1:0]       ra1 = '0;

  assign rsAddr = {ra1, ra0};

  gpr_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clock      (clock),
    .reset      (reset),
    .ready      (ready),
    .rsAddr     (rsAddr),
    .rsData     (rsData),
    .rsBusy     (rsBusy),
    .wbValid    (wbValid),
    .wbAddr     (wbAddr),
    .wbData     (wbData),
    .issueValid (issueValid),
    .issueRd    (issueRd),
    .flush      (flush),
    .dbgAddr    (dbgAddr),
    .dbgData    (dbgData)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference state: architectural register values, pending-write set, run flag.
  logic [XLEN-1:0] ref_mem [NREG];
  bit              ref_busy [NREG];
  bit              ref_run = 1'b0;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    ref_run = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      ref_mem[r]  = '0;
      ref_busy[r] = 1'b0;
    end
  endtask

  task automatic set_idle();
    wbValid    = 1'b0;
    issueValid = 1'b0;
    flush      = 1'b0;
  endtask

  // Advance one rising edge; the model consumes the inputs held across it.
  task automatic apply_edge();
    @(posedge clock);
    if (ref_run) begin
      if (flush) begin
        for (int r = 0; r < NREG; r++) ref_busy[r] = 1'b0;
      end else begin
        if (wbValid) ref_busy[wbAddr] = 1'b0;
        if (issueValid && issueRd != 0) ref_busy[issueRd] = 1'b1;
      end
      if (wbValid && wbAddr != 0) ref_mem[wbAddr] = wbData;
    end
    #1;
  endtask

  task automatic check_reads();
    logic [AW-1:0]   a;
    logic [XLEN-1:0] ed;
    logic            eb;
    for (int k = 0; k < NRD; k++) begin
      a = (k == 0) ? ra0 : ra1;
      if (!ref_run || a == 0) begin
        ed = '0; eb = 1'b0;
      end else if (wbValid && wbAddr == a) begin
        ed = wbData; eb = 1'b0;
      end else begin
        ed = ref_mem[a]; eb = ref_busy[a];
      end
      chk($sformatf("rd%0d_data@x%0d", k, a), rsData[k*XLEN +: XLEN], ed);
      chk($sformatf("rd%0d_busy@x%0d", k, a), XLEN'(rsBusy[k]), XLEN'(eb));
    end
    chk($sformatf("dbg@x%0d", dbgAddr), dbgData, ref_run ? ref_mem[dbgAddr] : '0);
  endtask

  task automatic release_reset();
    @(posedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic sweep(input bit noisy);
    for (int e = 1; e <= NREG - 1; e++) begin
      @(negedge clock);
      if (noisy) begin
        wbValid = 1'b1; wbAddr = 5'd3; wbData = {$urandom, $urandom};
        issueValid = 1'b1; issueRd = 5'd5; flush = (e == 20);
        ra0 = 5'd3; ra1 = 5'd5; dbgAddr = 5'd3;
      end
      #1;
      chk($sformatf("init_ready_e%0d", e - 1), XLEN'(ready), '0);
      if (noisy) check_reads();
      apply_edge();
      chk($sformatf("sweep_ready_e%0d", e), XLEN'(ready), XLEN'(e == NREG - 1));
    end
    ref_run = 1'b1;
    @(negedge clock);
    set_idle();
  endtask

  task automatic read_all();
    for (int r = 0; r < NREG; r++) begin
      @(negedge clock);
      ra0 = AW'(r); ra1 = AW'(NREG - 1 - r); dbgAddr = AW'(r);
      #1;
      check_reads();
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    model_clear();
    #3 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 chk("ready_in_reset", XLEN'(ready), '0);
    release_reset();
    sweep(1'b1);
    read_all();

    // Bypass of a same-cycle write and raw debug view.
    @(negedge clock);
    wbValid = 1'b1; wbAddr = 5'd5; wbData = 64'hDEAD_BEEF_0000_0001;
    ra0 = 5'd5; dbgAddr = 5'd5;
    #1;
    chk("x5_bypass", rsData[XLEN-1:0], 64'hDEAD_BEEF_0000_0001);
    chk("x5_dbg_old", dbgData, '0);
    apply_edge();
    @(negedge clock); set_idle(); #1;
    chk("x5_dbg_new", dbgData, 64'hDEAD_BEEF_0000_0001);
    chk("x5_read", rsData[XLEN-1:0], 64'hDEAD_BEEF_0000_0001);

    // x0 stays zero and never busy.
    @(negedge clock);
    wbValid = 1'b1; wbAddr = '0; wbData = '1; ra0 = '0; ra1 = '0; dbgAddr = '0;
    #1 chk("x0_no_bypass", rsData[XLEN-1:0], '0);
    apply_edge();
    @(negedge clock); set_idle(); #1;
    chk("x0_read", rsData[XLEN-1:0], '0);
    chk("x0_dbg", dbgData, '0);
    @(negedge clock); issueValid = 1'b1; issueRd = '0;
    apply_edge();
    @(negedge clock); set_idle(); #1;
    chk("x0_busy", XLEN'(rsBusy[0]), '0);

    // Issue/writeback priority on x7.
    @(negedge clock); issueValid = 1'b1; issueRd = 5'd7; ra0 = 5'd7;
    #1 chk("x7_busy_pre", XLEN'(rsBusy[0]), '0);
    apply_edge();
    @(negedge clock); set_idle(); #1;
    chk("x7_busy", XLEN'(rsBusy[0]), 64'd1);
    @(negedge clock);
    issueValid = 1'b1; issueRd = 5'd7; wbValid = 1'b1; wbAddr = 5'd7; wbData = 64'h1234;
    #1 chk("x7_mask_issue_wb", XLEN'(rsBusy[0]), '0);
    apply_edge();
    @(negedge clock); set_idle(); #1;
    chk("x7_reissue_busy", XLEN'(rsBusy[0]), 64'd1);
    chk("x7_data_1234", rsData[XLEN-1:0], 64'h1234);
    @(negedge clock); wbValid = 1'b1; wbAddr = 5'd7; wbData = 64'h5678;
    #1;
    chk("x7_wb_mask", XLEN'(rsBusy[0]), '0);
    chk("x7_wb_bypass", rsData[XLEN-1:0], 64'h5678);
    apply_edge();
    @(negedge clock); set_idle(); #1;
    chk("x7_cleared", XLEN'(rsBusy[0]), '0);

    // Flush beats a concurrent issue.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); issueValid = 1'b1;
      issueRd = (i == 0) ? 5'd3 : (i == 1) ? 5'd4 : 5'd9;
      apply_edge();
    end
    @(negedge clock); set_idle(); ra0 = 5'd3; ra1 = 5'd9; #1;
    chk("x3_busy", XLEN'(rsBusy[0]), 64'd1);
    chk("x9_busy", XLEN'(rsBusy[1]), 64'd1);
    @(negedge clock); flush = 1'b1; issueValid = 1'b1; issueRd = 5'd12;
    apply_edge();
    @(negedge clock); set_idle(); ra0 = 5'd12; #1;
    chk("x12_not_busy", XLEN'(rsBusy[0]), '0);
    read_all();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      wbValid    = 1'($urandom_range(0, 1));
      wbAddr     = rand_addr();
      wbData     = {$urandom, $urandom};
      issueValid = 1'($urandom_range(0, 1));
      issueRd    = rand_addr();
      flush      = ($urandom_range(0, 19) == 0);
      ra0 = rand_addr(); ra1 = rand_addr(); dbgAddr = rand_addr();
      #1 check_reads();
      apply_edge();
    end
    @(negedge clock); set_idle();

    // Asynchronous reset during RUN with a pending write.
    issueValid = 1'b1; issueRd = 5'd20;
    apply_edge();
    @(negedge clock); set_idle(); ra0 = 5'd20; #1;
    chk("x20_busy", XLEN'(rsBusy[0]), 64'd1);
    @(posedge clock); #2 reset = 1'b0; model_clear();
    #1;
    chk("run_rst_ready", XLEN'(ready), '0);
    chk("run_rst_busy", XLEN'(rsBusy[0]), '0);
    release_reset();

    // Reset again after sweep edge 10; sweep must restart from the beginning.
    repeat (10) @(posedge clock);
    #2 reset = 1'b0;
    #1 chk("sweep_rst_ready", XLEN'(ready), '0);
    release_reset();
    sweep(1'b0);
    read_all();
    @(negedge clock); ra0 = 5'd20; #1;
    chk("x20_after_reset", XLEN'(rsBusy[0]), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
